// File: rtl/weight_drm_ctrl_if.sv
// Command, weight-stream and bank-port bundle for the weight DRM sequencer.
interface weight_drm_ctrl_if #(
  parameter int unsigned DATA_IN_WIDTH = 324,
  parameter int unsigned WR_ADDR_DEPTH = 10,
  parameter int unsigned RD_ADDR_DEPTH = 8,
  parameter int unsigned REP_WIDTH     = 8
);
  logic [WR_ADDR_DEPTH:0]   cfg_load_words;
  logic [RD_ADDR_DEPTH:0]   cfg_rd_words;
  logic [REP_WIDTH-1:0]     cfg_rd_repeat;
  logic                     load_start;
  logic                     rd_start;
  logic [DATA_IN_WIDTH-1:0] s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic [DATA_IN_WIDTH-1:0] drm_wr_data;
  logic                     drm_wr_en;
  logic [WR_ADDR_DEPTH-1:0] drm_wr_addr;
  logic [RD_ADDR_DEPTH-1:0] drm_rd_addr;
  logic                     rd_valid;
  logic                     rd_last;
  logic                     load_done;
  logic                     rd_done;
  logic                     busy;
  logic                     loaded;
  logic                     err;

  modport master (
    output cfg_load_words, cfg_rd_words, cfg_rd_repeat, load_start, rd_start,
           s_data, s_valid,
    input  s_ready, drm_wr_data, drm_wr_en, drm_wr_addr, drm_rd_addr,
           rd_valid, rd_last, load_done, rd_done, busy, loaded, err
  );

  modport slave (
    input  cfg_load_words, cfg_rd_words, cfg_rd_repeat, load_start, rd_start,
           s_data, s_valid,
    output s_ready, drm_wr_data, drm_wr_en, drm_wr_addr, drm_rd_addr,
           rd_valid, rd_last, load_done, rd_done, busy, loaded, err
  );
endinterface

// File: rtl/weight_drm_ctrl.sv
// Load/read sequencer for the weight DRM bank: streams weights in, then replays reads.
module weight_drm_ctrl #(
  parameter int unsigned DATA_IN_WIDTH = 324,
  parameter int unsigned WR_ADDR_DEPTH = 10,
  parameter int unsigned RD_ADDR_DEPTH = 8,
  parameter int unsigned RD_LATENCY    = 2,
  parameter int unsigned REP_WIDTH     = 8
) (
  input logic              clk,
  input logic              rst,
  weight_drm_ctrl_if.slave bus
);

  localparam int unsigned WCW = WR_ADDR_DEPTH + 1;
  localparam int unsigned RCW = RD_ADDR_DEPTH + 1;
  localparam int unsigned FLW = 3;

  typedef enum logic [2:0] {IDLE, LOAD, LOADED, READ, FLUSH} state_t;

  state_t state, next_state;

  logic [WCW-1:0]        load_words, wr_cnt;
  logic [RCW-1:0]        rd_words, rd_cnt;
  logic [REP_WIDTH-1:0]  rep, pass_cnt;
  logic [FLW-1:0]        fl_cnt;
  logic [RD_LATENCY-1:0] vld_sr, last_sr;
  logic                  err_q, load_done_q, busy_q, loaded_q;

  logic accept, wr_last, rd_wrap, rd_final, load_ok, rd_ok, flush_end;
  logic start_load, start_read, issue, cmd_err, load_done_d, busy_d, loaded_d;

  // Shared compare terms; counters carry one extra bit so full-depth counts compare cleanly
  assign accept    = bus.s_valid && (state == LOAD);
  assign wr_last   = (wr_cnt == load_words - WCW'(1));
  assign rd_wrap   = (rd_cnt == rd_words - RCW'(1));
  assign rd_final  = rd_wrap && (pass_cnt == rep);
  assign load_ok   = bus.load_start && (bus.cfg_load_words != '0);
  assign rd_ok     = bus.rd_start && (bus.cfg_rd_words != '0);
  assign flush_end = (fl_cnt == FLW'(RD_LATENCY - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; in LOADED a load request outranks a read request
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (load_ok) next_state = LOAD;
      LOAD:    if (accept && wr_last) next_state = LOADED;
      LOADED: begin
        if (bus.load_start) begin
          if (load_ok) next_state = LOAD;
        end else if (rd_ok) begin
          next_state = READ;
        end
      end
      READ:    if (rd_final) next_state = FLUSH;
      FLUSH:   if (flush_end) next_state = LOADED;
      default: next_state = IDLE;
    endcase
  end

  // Control strobes and next values of the registered status outputs
  always_comb begin
    start_load  = 1'b0;
    start_read  = 1'b0;
    issue       = 1'b0;
    cmd_err     = 1'b0;
    load_done_d = 1'b0;
    busy_d      = 1'b0;
    loaded_d    = 1'b0;
    case (state)
      IDLE: begin
        start_load = load_ok;
        cmd_err    = bus.rd_start || (bus.load_start && !load_ok);
      end
      LOADED: begin
        start_load = load_ok;
        start_read = !bus.load_start && rd_ok;
        if (bus.load_start) cmd_err = !load_ok || bus.rd_start;
        else                cmd_err = bus.rd_start && !rd_ok;
      end
      LOAD: begin
        cmd_err     = bus.load_start || bus.rd_start;
        load_done_d = accept && wr_last;
      end
      READ: begin
        cmd_err = bus.load_start || bus.rd_start;
        issue   = 1'b1;
      end
      default: cmd_err = bus.load_start || bus.rd_start;
    endcase
    busy_d   = (next_state == LOAD) || (next_state == READ) || (next_state == FLUSH);
    loaded_d = (next_state == LOADED) || (next_state == READ) || (next_state == FLUSH);
  end

  // Counters, read-valid pipeline and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_words  <= '0;
      wr_cnt      <= '0;
      rd_words    <= '0;
      rd_cnt      <= '0;
      rep         <= '0;
      pass_cnt    <= '0;
      fl_cnt      <= '0;
      vld_sr      <= '0;
      last_sr     <= '0;
      err_q       <= 1'b0;
      load_done_q <= 1'b0;
      busy_q      <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      if (start_load) begin
        load_words <= bus.cfg_load_words;
        wr_cnt     <= '0;
      end else if (accept) begin
        wr_cnt <= wr_cnt + WCW'(1);
      end

      if (start_read) begin
        rd_words <= bus.cfg_rd_words;
        rep      <= bus.cfg_rd_repeat;
        rd_cnt   <= '0;
        pass_cnt <= '0;
      end else if (issue) begin
        if (rd_wrap) begin
          rd_cnt   <= '0;
          pass_cnt <= pass_cnt + REP_WIDTH'(1);
        end else begin
          rd_cnt <= rd_cnt + RCW'(1);
        end
      end

      if (state == FLUSH) fl_cnt <= fl_cnt + FLW'(1);
      else                fl_cnt <= '0;

      vld_sr[0]  <= issue;
      last_sr[0] <= issue && rd_final;
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end

      err_q       <= cmd_err;
      load_done_q <= load_done_d;
      busy_q      <= busy_d;
      loaded_q    <= loaded_d;
    end
  end

  assign bus.s_ready     = (state == LOAD);
  assign bus.drm_wr_data = bus.s_data;
  assign bus.drm_wr_en   = accept;
  assign bus.drm_wr_addr = wr_cnt[WR_ADDR_DEPTH-1:0];
  assign bus.drm_rd_addr = rd_cnt[RD_ADDR_DEPTH-1:0];
  assign bus.rd_valid    = vld_sr[RD_LATENCY-1];
  assign bus.rd_last     = last_sr[RD_LATENCY-1];
  assign bus.rd_done     = last_sr[RD_LATENCY-1];
  assign bus.load_done   = load_done_q;
  assign bus.busy        = busy_q;
  assign bus.loaded      = loaded_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_weight_drm_ctrl.sv
// Scoreboard bench for weight_drm_ctrl: directed stimulus, decoupled write/read monitor.
module tb_weight_drm_ctrl;

  localparam int unsigned DW = 324;
  localparam int unsigned WA = 10;
  localparam int unsigned RA = 8;
  localparam int unsigned RL = 2;
  localparam int unsigned RW = 8;

  typedef struct { logic [WA-1:0] addr; logic [DW-1:0] data; } wr_exp_t;
  typedef struct { logic [RA-1:0] addr; logic last; } rd_exp_t;

  logic clk, rst;
  int n_vec = 0, n_fail = 0;
  int err_cnt = 0, ld_cnt = 0, rdd_cnt = 0;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  logic [RA-1:0] bank_pipe [RL];

  weight_drm_ctrl_if #(.DATA_IN_WIDTH(DW), .WR_ADDR_DEPTH(WA), .RD_ADDR_DEPTH(RA),
                       .REP_WIDTH(RW)) bus ();

  weight_drm_ctrl #(.DATA_IN_WIDTH(DW), .WR_ADDR_DEPTH(WA), .RD_ADDR_DEPTH(RA),
                    .RD_LATENCY(RL), .REP_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [DW-1:0] data_of(input int i);
    logic [9:0] v;
    v = 10'(i);
    return {4'hA, v, {31{v}}};
  endfunction

  function automatic void chk(input string nm, input logic signed [63:0] act,
                              input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void chk_data(input string nm, input logic [DW-1:0] act,
                                   input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Behavioural bank read port: address to data in RL cycles
  always @(posedge clk) begin
    bank_pipe[0] <= bus.drm_rd_addr;
    for (int i = 1; i < int'(RL); i++) bank_pipe[i] <= bank_pipe[i-1];
  end

  // Monitor: pops the scoreboard whenever the DUT writes or presents read data
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.drm_wr_en) begin
        if (wr_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_write: addr %0d, none expected", bus.drm_wr_addr);
        end else begin
          wr_exp_t e;
          e = wr_q.pop_front();
          chk("wr_addr", bus.drm_wr_addr, e.addr);
          chk_data("wr_data", bus.drm_wr_data, e.data);
        end
      end
      if (bus.rd_valid) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_rd_valid: addr %0d, none expected", bank_pipe[RL-1]);
        end else begin
          rd_exp_t r;
          r = rd_q.pop_front();
          chk("rd_addr", bank_pipe[RL-1], r.addr);
          chk("rd_last", bus.rd_last, r.last);
          chk("rd_done_with_last", bus.rd_done, r.last);
        end
      end else if (bus.rd_done) begin
        n_vec++; n_fail++;
        $display("FAIL rd_done_no_valid: got 1 expected 0");
      end
      if (bus.err)       err_cnt++;
      if (bus.load_done) ld_cnt++;
      if (bus.rd_done)   rdd_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int words, input bit gapped);
    int beat;
    bit v;
    beat = 0;
    for (int k = 0; k < 4 * words + 8 && beat < words; k++) begin
      v = !gapped || (k % 2 == 0);
      bus.s_valid = v;
      if (v) begin
        bus.s_data = data_of(beat);
        wr_q.push_back('{addr: WA'(beat), data: data_of(beat)});
        beat++;
      end else begin
        bus.s_data = ~data_of(k);
      end
      tick();
    end
    bus.s_valid = !gapped;
    #1;
    chk("ready_low_after_last", bus.s_ready, 0);
    chk("no_write_after_last", bus.drm_wr_en, 0);
    chk("load_done_pulse", bus.load_done, 1);
    chk("loaded_after_load", {bus.busy, bus.loaded}, 2'b01);
    bus.s_valid = 1'b0;
    tick();
    chk("load_done_single", bus.load_done, 0);
  endtask

  task automatic do_load(input int words, input bit gapped);
    bus.cfg_load_words = (WA+1)'(words);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    chk("load_entered", {bus.busy, bus.loaded, bus.s_ready}, 3'b101);
    feed(words, gapped);
  endtask

  task automatic run_read(input int words, input int rep, input int inj);
    int first, done_cyc;
    bus.cfg_rd_words  = (RA+1)'(words);
    bus.cfg_rd_repeat = RW'(rep);
    bus.rd_start = 1'b1;
    for (int p = 0; p <= rep; p++)
      for (int a = 0; a < words; a++)
        rd_q.push_back('{addr: RA'(a), last: (p == rep && a == words - 1)});
    tick();
    bus.rd_start = 1'b0;
    chk("read_busy", bus.busy, 1);
    first = -1;
    done_cyc = -1;
    for (int c = 0; c < 4000; c++) begin
      if (inj >= 0 && c == inj) begin
        bus.cfg_load_words = (WA+1)'(5);
        bus.load_start = 1'b1;
      end
      if (inj >= 0 && c == inj + 1) begin
        bus.load_start = 1'b0;
        chk("err_load_in_read", bus.err, 1);
        chk("read_continues", {bus.busy, bus.s_ready}, 2'b10);
      end
      if (bus.rd_valid && first < 0) first = c;
      if (bus.rd_done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    chk("read_first_valid", first, RL);
    chk("read_done_cycle", done_cyc, words * (rep + 1) - 1 + RL);
    tick();
    chk("read_back_loaded", {bus.busy, bus.loaded}, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    bus.load_start = 1'b0;
    bus.rd_start = 1'b0;
    bus.cfg_load_words = '0;
    bus.cfg_rd_words = '0;
    bus.cfg_rd_repeat = '0;
    bus.s_valid = 1'b0;
    bus.s_data = data_of(7);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flags", {bus.s_ready, bus.drm_wr_en, bus.rd_valid, bus.rd_last, bus.load_done,
                        bus.rd_done, bus.busy, bus.loaded, bus.err}, 0);
    chk("reset_wr_addr", bus.drm_wr_addr, 0);
    chk("reset_rd_addr", bus.drm_rd_addr, 0);
    chk_data("reset_wr_data_mirror", bus.drm_wr_data, data_of(7));
    rst = 1'b0;
    tick();

    // Full-depth continuous load, then an 8-word gapped reload
    do_load(1024, 1'b0);
    do_load(8, 1'b1);

    // Two full-depth passes
    run_read(256, 1, -1);

    // Load and read together in LOADED: load wins, err pulses
    bus.cfg_load_words = (WA+1)'(3);
    bus.cfg_rd_words = (RA+1)'(4);
    bus.load_start = 1'b1;
    bus.rd_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.rd_start = 1'b0;
    chk("both_cmd_err", bus.err, 1);
    chk("both_cmd_enters_load", {bus.busy, bus.loaded, bus.s_ready}, 3'b101);
    feed(3, 1'b0);

    // Load request during a read is rejected and the read completes
    run_read(4, 0, 1);

    // Async reset ten cycles into a long read
    bus.cfg_rd_words = (RA+1)'(256);
    bus.cfg_rd_repeat = '0;
    bus.rd_start = 1'b1;
    for (int a = 0; a < 256; a++) rd_q.push_back('{addr: RA'(a), last: (a == 255)});
    tick();
    bus.rd_start = 1'b0;
    repeat (9) tick();
    #2;
    rst = 1'b1;
    rd_q.delete();
    #1;
    chk("arst_flags", {bus.s_ready, bus.drm_wr_en, bus.rd_valid, bus.rd_last, bus.load_done,
                       bus.rd_done, bus.busy, bus.loaded, bus.err}, 0);
    chk("arst_rd_addr", bus.drm_rd_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // Read in IDLE is rejected; bank must be reloaded
    bus.cfg_rd_words = (RA+1)'(1);
    bus.rd_start = 1'b1;
    tick();
    bus.rd_start = 1'b0;
    chk("err_rd_in_idle", bus.err, 1);
    chk("idle_after_rd_err", {bus.busy, bus.loaded}, 0);
    tick();
    chk("err_single_pulse", bus.err, 0);

    // Reload, two back-to-back single-word reads, then reload again
    do_load(4, 1'b0);
    run_read(1, 0, -1);
    run_read(1, 0, -1);
    do_load(2, 1'b0);

    repeat (4) tick();
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    chk("err_pulse_total", err_cnt, 3);
    chk("load_done_total", ld_cnt, 5);
    chk("rd_done_total", rdd_cnt, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_drm_ctrl.md
Name: weight_drm_ctrl

Overview:
Single-clock sequencer for the weight DRM bank (36-bit write lanes, 144-bit read lanes, 4:1 width ratio).
- Load phase: accepts a valid/ready stream of packed weight words and generates sequential write strobes and addresses into the bank.
- Compute phase: on command from the conv engine, issues sequential read addresses, repeated a configurable number of times, with a data-aligned valid/last.
- Load and read are mutually exclusive; weights persist in the bank and can be re-read without reloading.

Parameters:
- DATA_IN_WIDTH, 324, packed write word width (passed straight through to the bank)
- WR_ADDR_DEPTH, 10, bank write address width
- RD_ADDR_DEPTH, 8, bank read address width
- RD_LATENCY, 2, cycles from drm_rd_addr change to matching bank read data (valid range 1..4)
- REP_WIDTH, 8, width of read-repeat count

Ports:
- clk  in  1  single clock, shared by both bank ports
- rst  in  1  asynchronous, active-high reset
- cfg_load_words  in  WR_ADDR_DEPTH+1  words to load (1..2^WR_ADDR_DEPTH); sampled on accepted load_start
- cfg_rd_words  in  RD_ADDR_DEPTH+1  read words per pass (1..2^RD_ADDR_DEPTH); sampled on accepted rd_start
- cfg_rd_repeat  in  REP_WIDTH  number of passes minus 1; sampled on accepted rd_start
- load_start  in  1  one-cycle load request
- rd_start  in  1  one-cycle read request
- s_data  in  DATA_IN_WIDTH  weight stream data
- s_valid  in  1  weight stream valid
- s_ready  out  1  weight stream ready
- drm_wr_data  out  DATA_IN_WIDTH  equals s_data (combinational)
- drm_wr_en  out  1  bank write enable
- drm_wr_addr  out  WR_ADDR_DEPTH  bank write address
- drm_rd_addr  out  RD_ADDR_DEPTH  bank read address (registered)
- rd_valid  out  1  bank read data valid, aligned to bank output
- rd_last  out  1  with rd_valid on the final word of the final pass
- load_done  out  1  one-cycle pulse
- rd_done  out  1  one-cycle pulse
- busy  out  1  high in LOAD, READ, FLUSH
- loaded  out  1  bank holds a complete load
- err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (async, rst=1): state IDLE; all counters 0; every output 0 (drm_wr_data excepted, it mirrors s_data). Reset mid-LOAD or mid-READ aborts immediately; loaded=0, so the bank must be reloaded.
- States: IDLE, LOAD, LOADED, READ, FLUSH.
- IDLE:
  - load_start with cfg_load_words != 0 -> LOAD; latch count; wr_cnt=0.
  - load_start with count 0, or rd_start -> err pulse next cycle; stay in IDLE.
- LOAD:
  - s_ready = (state==LOAD), combinational. drm_wr_en = s_valid & s_ready. drm_wr_addr = wr_cnt. Zero-latency pass-through.
  - Each accepted beat increments wr_cnt. Gaps in s_valid are allowed: no write, counter holds.
  - Final beat (wr_cnt == count-1) -> LOADED. load_done and loaded assert the following cycle.
- LOADED:
  - rd_start -> READ; latch words/repeat; rd_addr=0; pass=0.
  - load_start (count != 0) -> LOAD; loaded drops.
  - Both in the same cycle: load_start wins and err pulses.
  - Zero count on either command -> err pulse; stay.
- READ: one address issued per cycle.
  - drm_rd_addr = 0 on the first READ cycle, then increments.
  - After words-1 it wraps to 0 and pass increments.
  - Last issue (addr == words-1 and pass == repeat) -> FLUSH.
  - Total issues = words*(repeat+1).
- rd_valid/rd_last: the issue strobe and last-issue flag, delayed by an RD_LATENCY-stage shift register.
- FLUSH: wait RD_LATENCY cycles to drain the shift register. rd_done pulses in the same cycle as the final rd_valid; the next cycle the block returns to LOADED.
- Commands in LOAD/READ/FLUSH: ignored; err pulses the next cycle.
- Width rules:
  - Counters are one bit wider than the address only for comparing against counts of 2^N.
  - Address outputs are the low bits.
  - Full-depth loads (1024) and reads (256) must wrap cleanly with no extra write or read.

Test Plan:
- Continuous load: rst, load_start with cfg_load_words=1024, s_valid held high -> 1024 writes at addresses 0..1023, each with the matching s_data; s_ready low from the cycle after the last beat; load_done pulses once; loaded=1.
- Gapped load: cfg_load_words=8, s_valid toggling 1010... -> exactly 8 writes at addresses 0..7, no write while s_valid=0; load_done 1 cycle after the 8th beat.
- Repeat read: after a load, rd_start with cfg_rd_words=256 and cfg_rd_repeat=1 -> addresses 0..255,0..255 on 512 consecutive cycles; rd_valid high exactly 512 cycles, starting RD_LATENCY cycles after the first address; rd_last and rd_done coincide on the 512th valid; return to LOADED.
- Illegal commands: rd_start in IDLE, load_start during READ, and load_start+rd_start together in LOADED -> err pulse each time; the first two change nothing; the third enters LOAD.
- Async reset mid-read: assert rst 10 cycles into a READ -> all outputs 0 immediately, state IDLE, loaded=0; a subsequent rd_start gives err.
- Reread/reload: two back-to-back READs (cfg_rd_words=1, repeat=0) -> each gives exactly one rd_valid with rd_last; then load_start reloads successfully.
